// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register:
// control-bit positions, payload field offsets and buffer occupancy states.
package pipe_pkg;

  localparam int unsigned CTRL_MEMR  = 3;
  localparam int unsigned CTRL_MEMW  = 2;
  localparam int unsigned CTRL_REGW  = 1;
  localparam int unsigned CTRL_MEM2R = 0;

  localparam int unsigned NPC_MSB     = 95;
  localparam int unsigned NPC_LSB     = 64;
  localparam int unsigned ALU_C_MSB   = 63;
  localparam int unsigned ALU_C_LSB   = 32;
  localparam int unsigned RT_DATA_MSB = 31;
  localparam int unsigned RT_DATA_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones until reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between CPU stages: valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 96,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned RD_W    = 5,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [RD_W-1:0]    in_rd,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
  output logic [RD_W-1:0]    out_rd,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [CNT_W-1:0]   stall_cnt
);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;

  logic [DATA_W-1:0]  main_data_q,  main_data_d,  skid_data_q,  skid_data_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [RD_W-1:0]    main_rd_q,    main_rd_d,    skid_rd_q,    skid_rd_d;
  logic [CTRL_W-1:0]  main_ctrl_q,  main_ctrl_d,  skid_ctrl_q,  skid_ctrl_d;

  logic in_fire, out_fire;

  // in_ready_q is low during reset and the first cycle after it; in SKID mode it
  // is the whole ready (no path from out_ready), otherwise it only gates reset.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q
                                 : (in_ready_q && (!out_valid || out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_instr_d = main_instr_q;
    main_rd_d    = main_rd_q;
    main_ctrl_d  = main_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_instr_d = skid_instr_q;
    skid_rd_d    = skid_rd_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d  = in_data;
            main_instr_d = in_instr;
            main_rd_d    = in_rd;
            main_ctrl_d  = in_ctrl;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d  = in_data;
            main_instr_d = in_instr;
            main_rd_d    = in_rd;
            main_ctrl_d  = in_ctrl;
          end else if (in_fire && (SKID != 0)) begin
            skid_data_d  = in_data;
            skid_instr_d = in_instr;
            skid_rd_d    = in_rd;
            skid_ctrl_d  = in_ctrl;
            state_d      = FULL;
          end else if (out_fire) begin
            main_ctrl_d = '0;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_d  = skid_data_q;
            main_instr_d = skid_instr_q;
            main_rd_d    = skid_rd_q;
            main_ctrl_d  = skid_ctrl_q;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b0;
      main_data_q  <= '0;
      main_instr_q <= '0;
      main_rd_q    <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_instr_q <= '0;
      skid_rd_q    <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      main_instr_q <= main_instr_d;
      main_rd_q    <= main_rd_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_instr_q <= skid_instr_d;
      skid_rd_q    <= skid_rd_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_instr = main_instr_q;
  assign out_rd    = main_rd_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a SKID=1/CNT_W=4 and a SKID=0/CNT_W=16 instance
// share stimulus, each checked every cycle against a FIFO-occupancy model.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int unsigned DW = 96;
  localparam int unsigned IW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] C_REGW = CW'(1 << CTRL_REGW);
  localparam logic [CW-1:0] C_MEMW = CW'(1 << CTRL_MEMW);
  localparam logic [CW-1:0] C_LOAD = CW'((1 << CTRL_MEMR) | (1 << CTRL_MEM2R));

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_instr;
  logic [RW-1:0] in_rd;
  logic [CW-1:0] in_ctrl;

  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [IW-1:0] out_instr_a, out_instr_b;
  logic [RW-1:0] out_rd_a, out_rd_b;
  logic [CW-1:0] out_ctrl_a, out_ctrl_b;
  logic [3:0]    stall_cnt_a;
  logic [15:0]   stall_cnt_b;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W(DW), .INSTR_W(IW), .RD_W(RW), .CTRL_W(CW), .SKID(1), .CNT_W(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_instr(in_instr), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_instr(out_instr_a), .out_rd(out_rd_a),
    .out_ctrl(out_ctrl_a), .stall_cnt(stall_cnt_a)
  );

  pipe_stage_elastic #(
    .DATA_W(DW), .INSTR_W(IW), .RD_W(RW), .CTRL_W(CW), .SKID(0), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_instr(in_instr), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_instr(out_instr_b), .out_rd(out_rd_b),
    .out_ctrl(out_ctrl_b), .stall_cnt(stall_cnt_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k=0 is the 2-deep skid instance, k=1 the single-register instance.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } ent_t;

  ent_t        fifo [2][2];
  ent_t        held [2];
  int unsigned cnt [2];
  int unsigned stall [2];
  bit          started [2];

  function automatic int unsigned smax(input int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  function automatic bit m_rdy(input int k);
    if (!started[k]) return 1'b0;
    if (k == 0) return cnt[0] < 2;
    return (cnt[1] == 0) || out_ready;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; stall[k] = 0; started[k] = 1'b0; held[k] = '0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      bit   inf, outf;
      ent_t e;
      inf  = in_valid && m_rdy(k);
      outf = (cnt[k] > 0) && out_ready;
      if ((cnt[k] > 0) && !out_ready && (stall[k] < smax(k))) stall[k]++;
      started[k] = 1'b1;
      if (flush) begin
        cnt[k] = 0;
      end else begin
        if (outf) begin
          fifo[k][0] = fifo[k][1];
          cnt[k]--;
        end
        if (inf) begin
          e.d = in_data; e.i = in_instr; e.r = in_rd; e.c = in_ctrl;
          fifo[k][cnt[k]] = e;
          cnt[k]++;
        end
      end
      if (cnt[k] > 0) held[k] = fifo[k][0];
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  task automatic cmp_dut(input int k, input logic v, input logic r, input logic [DW-1:0] d,
                         input logic [IW-1:0] i, input logic [RW-1:0] rd,
                         input logic [CW-1:0] c, input logic [15:0] s);
    string p;
    bit    ev;
    p  = (k == 0) ? "skid" : "reg";
    ev = cnt[k] > 0;
    chk({p, "_out_valid"}, v, ev);
    chk({p, "_in_ready"}, r, m_rdy(k));
    chk({p, "_out_data"}, d, held[k].d);
    chk({p, "_out_instr"}, i, held[k].i);
    chk({p, "_out_rd"}, rd, held[k].r);
    chk({p, "_out_ctrl"}, c, ev ? held[k].c : '0);
    chk({p, "_stall_cnt"}, s, stall[k]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_dut(0, out_valid_a, in_ready_a, out_data_a, out_instr_a, out_rd_a, out_ctrl_a,
              16'(stall_cnt_a));
      cmp_dut(1, out_valid_b, in_ready_b, out_data_b, out_instr_b, out_rd_b, out_ctrl_b,
              stall_cnt_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit r);
    in_valid  = v;
    in_data   = d;
    in_instr  = {16'hC0DE, d[15:0]};
    in_rd     = d[RW-1:0];
    in_ctrl   = c;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] abc [3];
    logic [DW-1:0] outs [$];
    int unsigned   pat [6];
    int unsigned   idx;
    bit            acc;

    // Reset state and in_ready release timing
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) step();
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_stall", stall_cnt_a, 4'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_same_cycle", in_ready_a, 1'b0);
    step();
    chk("rel_in_ready_skid", in_ready_a, 1'b1);
    chk("rel_in_ready_reg", in_ready_b, 1'b1);

    // 1: single entry, one-cycle latency
    drive(1'b1, 96'h1, C_REGW, 1'b1);
    step();
    chk("t1_valid_skid", out_valid_a, 1'b1);
    chk("t1_data_skid", out_data_a, 96'h1);
    chk("t1_ctrl_skid", out_ctrl_a, 4'b0010);
    chk("t1_valid_reg", out_valid_b, 1'b1);
    chk("t1_ctrl_reg", out_ctrl_b, 4'b0010);
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) step();

    // 2: skid fills with A,B; C waits; drain in order without gaps
    abc[0] = 96'hAAAA; abc[1] = 96'hBBBB; abc[2] = 96'hCCCC;
    drive(1'b1, abc[0], C_MEMW, 1'b0);
    step();
    chk("t2_ready_after_A", in_ready_a, 1'b1);
    drive(1'b1, abc[1], C_MEMW, 1'b0);
    step();
    chk("t2_ready_full", in_ready_a, 1'b0);
    drive(1'b1, abc[2], C_MEMW, 1'b0);
    step();
    chk("t2_ready_held", in_ready_a, 1'b0);
    drive(1'b1, abc[2], C_MEMW, 1'b1);
    for (int j = 0; j < 3; j++) begin
      chk("t2_drain_valid", out_valid_a, 1'b1);
      chk("t2_drain_data", out_data_a, abc[j]);
      step();
      if (j == 1) in_valid = 1'b0;
    end
    chk("t2_empty_after", out_valid_a, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) step();

    // 3: single-register mode with toggling out_ready
    do_reset();
    pat = '{1, 0, 1, 0, 1, 1};
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 96'h100 + DW'(idx), C_REGW, pat[i] != 0);
      #1;
      if (out_valid_b) chk("t3_ready_tracks", in_ready_b, out_ready);
      if (out_valid_b && out_ready) outs.push_back(out_data_b);
      acc = in_ready_b;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (out_valid_b && out_ready) outs.push_back(out_data_b);
      step();
    end
    chk("t3_stall_cnt", stall_cnt_b, 16'd2);
    chk("t3_out_count", outs.size(), 4);
    foreach (outs[j]) chk("t3_order", outs[j], 96'h100 + DW'(j));

    // 4: flush a full skid buffer while an input is offered
    drive(1'b1, 96'hE0E0, C_MEMW | C_REGW, 1'b0);
    step();
    drive(1'b1, 96'hF0F0, C_MEMW | C_REGW, 1'b0);
    step();
    chk("t4_full", in_ready_a, 1'b0);
    flush = 1'b1;
    drive(1'b1, 96'h6060, C_MEMW | C_REGW, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    chk("t4_valid_cleared", out_valid_a, 1'b0);
    chk("t4_ctrl_zero", out_ctrl_a, 4'b0000);
    chk("t4_ready_back", in_ready_a, 1'b1);
    chk("t4_valid_cleared_reg", out_valid_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_ghost", out_valid_a, 1'b0);
      step();
    end

    // 5: stall counter saturation
    do_reset();
    drive(1'b1, 96'h5555, C_LOAD, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    repeat (15) step();
    chk("t5_sat_reached", stall_cnt_a, 4'd15);
    repeat (5) step();
    chk("t5_sat_held", stall_cnt_a, 4'd15);
    chk("t5_wide_cnt", stall_cnt_b, 16'd20);

    // 6: asynchronous reset while full
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) step();
    drive(1'b1, 96'h7A7A, C_MEMW, 1'b0);
    step();
    drive(1'b1, 96'h7B7B, C_MEMW, 1'b0);
    step();
    chk("t6_full", in_ready_a, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", out_valid_a, 1'b0);
    chk("t6_async_data", out_data_a, '0);
    chk("t6_async_instr", out_instr_a, '0);
    chk("t6_async_ctrl", out_ctrl_a, '0);
    chk("t6_async_ready", in_ready_a, 1'b0);
    chk("t6_async_stall", stall_cnt_a, 4'd0);
    chk("t6_async_valid_reg", out_valid_b, 1'b0);
    chk("t6_async_data_reg", out_data_b, '0);
    step();
    chk("t6_ready_in_rst", in_ready_b, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("t6_ready_at_release", in_ready_a, 1'b0);
    step();
    chk("t6_ready_after", in_ready_a, 1'b1);
    chk("t6_ready_after_reg", in_ready_b, 1'b1);
    chk("t6_valid_after", out_valid_a, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised inter-stage pipeline register for the CPU datapath, e.g. ID/EX, EX/MEM or MEM/WB. It carries a data payload, a destination-register index and a control-bit vector through a valid/ready handshake. It adds stall (back-pressure), synchronous flush (bubble insertion) and an optional 2-entry skid buffer. In the skid configuration `in_ready` has no combinational path from `out_ready`. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 96, payload width in bits; the shared package defines field offsets (NPC, ALU_C, RT_DATA).
- INSTR_W, 32, width of the instruction field, carried separately for debug and trace.
- RD_W, 5, width of the destination register index.
- CTRL_W, 4, width of the control vector; bit order {MEMR, MEMW, REGW, MEM2R} from bit 3 down to bit 0.
- SKID, 1, selects the buffer: 1 = 2-entry skid buffer, 0 = single register with stall.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_data  in  DATA_W  payload
- in_instr  in  INSTR_W  instruction word
- in_rd  in  RD_W  destination register index
- in_ctrl  in  CTRL_W  control bits
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts the entry
- out_data  out  DATA_W  registered payload
- out_instr  out  INSTR_W  registered instruction word
- out_rd  out  RD_W  registered destination index
- out_ctrl  out  CTRL_W  registered control bits; forced to 0 whenever out_valid=0
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset state: all registered outputs are 0, all internal valids are 0, stall_cnt=0.
  - in_ready=1 one cycle after rst deasserts. in_ready=0 while rst=1.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - Latency is 1 cycle from input transfer to out_valid, in both SKID modes.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On an input transfer, the output regs load the input and out_valid=1.
  - On an output transfer with no input transfer, out_valid=0 and out_ctrl=0; out_data, out_instr and out_rd hold their values.
- SKID=1: two registers, MAIN (drives the outputs) and SKIDREG, with states EMPTY, ONE, FULL. in_ready = (state != FULL), registered with no combinational path.
  - EMPTY: input transfer loads MAIN and goes to ONE.
  - ONE:
    - Input and output transfer together: MAIN loads the input, stay in ONE.
    - Input transfer only: SKIDREG loads the input, go to FULL.
    - Output transfer only: go to EMPTY.
  - FULL: output transfer moves SKIDREG to MAIN and goes to ONE. No input is accepted.
  - Ordering: strictly FIFO; entries are never dropped or duplicated.
- flush (highest priority after rst):
  - At the edge where flush=1, all valids clear, out_ctrl=0 and the state becomes EMPTY.
  - An input presented in the same cycle is discarded.
  - An output transfer in the same cycle still counts as consumed downstream.
  - stall_cnt is unaffected by flush.
- Control zeroing: out_ctrl equals the captured in_ctrl only while out_valid=1. A bubble can never assert MEMW or REGW.
- stall_cnt: increments each cycle with out_valid && !out_ready. It saturates at 2^CNT_W-1 with no wrap and is cleared only by rst.
- Reset mid-operation: rst asserted at any time clears everything immediately (asynchronous); in-flight entries are lost.

Decomposition:
- Package `pipe_pkg` holds:
  - the CTRL bit-index constants (CTRL_MEMR=3, CTRL_MEMW=2, CTRL_REGW=1, CTRL_MEM2R=0);
  - the payload field offsets (NPC 95:64, ALU_C 63:32, RT_DATA 31:0);
  - the state enum {EMPTY, ONE, FULL}.
- One natural sub-module, `sat_counter`, holds the CNT_W saturating counter with an increment enable. All other logic is flat.

Test Plan:
1. rst pulse, then in_valid=1, in_data=0x...0001, in_ctrl=4'b0010, out_ready=1 -> next cycle out_valid=1, out_data=0x...0001, out_ctrl=4'b0010.
2. SKID=1, out_ready=0, three back-to-back inputs A, B, C -> A and B accepted, in_ready=0 on the third cycle, C held. Then out_ready=1 -> outputs A, B, C in order, one per cycle, with no gaps.
3. SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready tracks out_ready whenever out_valid=1, no entry is lost, and stall_cnt=2 at the end.
4. State FULL, then flush=1 for one cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the flushed-cycle input never appears at the output.
5. CNT_W=4, out_valid=1, out_ready=0 held for 20 cycles -> stall_cnt reaches 15 and stays at 15.
6. rst asserted asynchronously mid-cycle while FULL -> all outputs 0 immediately, before the next clock edge; in_ready=0 during rst and 1 one cycle after release.
